// File: rtl/draw_sequencer_if.sv
// Client/VGA bundle shared by the draw sequencer, its drawing clients and the VGA adapter.
// Pure wiring, no latency.
// No backpressure: clients are handshaked by one-cycle start/done pulses only.
interface draw_sequencer_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]   client_start;
  logic [NUM_CLIENTS-1:0]   client_done;
  logic [8*NUM_CLIENTS-1:0] client_x;
  logic [7*NUM_CLIENTS-1:0] client_y;
  logic [3*NUM_CLIENTS-1:0] client_c;
  logic [7:0]               vga_x;
  logic [6:0]               vga_y;
  logic [2:0]               vga_colour;
  logic                     vga_plot;
  logic                     frame_tick;
  logic                     busy;
  logic                     timeout_err;
  logic                     overrun;

  modport master (
    output client_start, vga_x, vga_y, vga_colour, vga_plot,
           frame_tick, busy, timeout_err, overrun,
    input  client_done, client_x, client_y, client_c
  );

  modport slave (
    input  client_start, vga_x, vga_y, vga_colour, vga_plot,
           frame_tick, busy, timeout_err, overrun,
    output client_done, client_x, client_y, client_c
  );
endinterface

// File: rtl/draw_sequencer.sv
// Once per frame, starts each drawing client in turn and forwards its pixels to the VGA adapter.
// Pixel path is 1 cycle (registered); a client gets start, then up to TIMEOUT wait cycles.
// No backpressure: a frame pulse arriving while a sequence runs is dropped and flagged as overrun.
module draw_sequencer #(
  parameter int NUM_CLIENTS = 4,
  parameter int FRAME_DIV   = 833333,
  parameter int TIMEOUT     = 255
) (
  input logic              clk,
  input logic              resetn,
  draw_sequencer_if.master bus
);
  localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int FCNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_DIV - 1);
  // The counter holds the number of wait cycles already completed, so the
  // TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [FCNT_W-1:0]  frame_cnt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic               frame_pulse;
  logic               done_sel;
  logic               wait_expired;

  assign frame_pulse  = (frame_cnt == FRAME_LAST);
  assign done_sel     = bus.client_done[idx];
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign bus.busy     = (state != S_IDLE);

  // Free-running frame divider, wraps after FRAME_DIV cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          frame_cnt <= '0;
    else if (frame_pulse) frame_cnt <= '0;
    else                  frame_cnt <= frame_cnt + 1'b1;
  end

  // State and client index registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Sequencing decisions and the start pulse for the selected client.
  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    bus.client_start = '0;
    unique case (state)
      S_IDLE: begin
        if (frame_pulse) begin
          state_nxt = S_START;
          idx_nxt   = '0;
        end
      end
      S_START: begin
        bus.client_start[idx] = 1'b1;
        state_nxt             = S_WAIT;
      end
      S_WAIT: begin
        // Only the selected client's done counts; other bits are ignored.
        if (done_sel || wait_expired) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        // Always return to idle after the last client, even if a frame
        // pulse lands now; that pulse is reported as overrun instead.
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_START;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait counter: zero outside S_WAIT, so it is already clear on entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    else                       wait_cnt <= '0;
  end

  // Frame tick and the sticky error flags (cleared only by reset).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.frame_tick  <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.frame_tick <= (state == S_IDLE) && frame_pulse;
      if ((state == S_WAIT) && !done_sel && wait_expired) bus.timeout_err <= 1'b1;
      if ((state != S_IDLE) && frame_pulse)               bus.overrun     <= 1'b1;
    end
  end

  // Pixel forwarding: always track the selected slice; plot only for S_WAIT samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      bus.vga_x      <= bus.client_x[8*int'(idx) +: 8];
      bus.vga_y      <= bus.client_y[7*int'(idx) +: 7];
      bus.vga_colour <= bus.client_c[3*int'(idx) +: 3];
      bus.vga_plot   <= (state == S_WAIT);
    end
  end
endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: client responder model plus scoreboard of starts, ticks and pixels.
// Outputs sampled 1 time unit after each rising edge; inputs driven right after sampling.
// Second instance with a long timeout exercises dropped frame pulses (overrun).
module tb_draw_sequencer;
  localparam int NC   = 4;
  localparam int FDIV = 100;
  localparam int TO   = 20;
  localparam int TO_B = 60;

  logic clk      = 1'b0;
  logic resetn   = 1'b0;
  logic resetn_b = 1'b0;

  always #5 clk = ~clk;

  draw_sequencer_if #(.NUM_CLIENTS(NC)) bus ();
  draw_sequencer_if #(.NUM_CLIENTS(NC)) bus_b ();

  draw_sequencer #(.NUM_CLIENTS(NC), .FRAME_DIV(FDIV), .TIMEOUT(TO)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  draw_sequencer #(.NUM_CLIENTS(NC), .FRAME_DIV(FDIV), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .resetn(resetn_b), .bus(bus_b)
  );

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int cyc;
    int idx;
  } ev_t;

  pix_t pix_q[$];
  ev_t  start_q[$];
  int   tick_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcli  = -1;
  int wcyc  = 0;
  int dly[NC];
  bit inject_ign = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({bus.client_start, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot,
                bus.frame_tick, bus.busy, bus.timeout_err, bus.overrun});
  endfunction

  function automatic logic [31:0] outs_b();
    return 32'({bus_b.client_start, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour, bus_b.vga_plot,
                bus_b.frame_tick, bus_b.busy, bus_b.timeout_err, bus_b.overrun});
  endfunction

  // One clock: check outputs against the scoreboard, then drive client inputs.
  task automatic step();
    pix_t exp_p;
    pix_t got_p;
    ev_t  e;
    int   nxt;
    @(posedge clk);
    #1;
    cyc++;
    nxt   = -1;
    got_p = {bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour};
    if (pix_q.size() > 0) begin
      exp_p = pix_q.pop_front();
      if (exp_p.plot) check("pix", 32'(got_p), 32'(exp_p));
      else            check("plot_low", 32'(bus.vga_plot), 32'(0));
    end
    if (bus.frame_tick) begin
      if (tick_q.size() > 0) check("tick_cyc", 32'(cyc), 32'(tick_q.pop_front()));
      else                   check("tick_unexp", 32'(bus.frame_tick), 32'(0));
    end
    if (bus.client_start != '0) begin
      if (start_q.size() > 0) begin
        e = start_q.pop_front();
        check("start_cyc", 32'(cyc), 32'(e.cyc));
        check("start_vec", 32'(bus.client_start), 32'(1) << e.idx);
        nxt = e.idx;
      end else begin
        check("start_unexp", 32'(bus.client_start), 32'(0));
      end
    end
    bus.client_done = '0;
    bus.client_x    = $urandom();
    bus.client_y    = 28'($urandom());
    bus.client_c    = 12'($urandom());
    if (wcli >= 0) begin
      if (wcli == 1 && wcyc == 2) begin
        bus.client_x[8*wcli +: 8] = 8'd75;
        bus.client_y[7*wcli +: 7] = 7'd120;
        bus.client_c[3*wcli +: 3] = 3'd7;
      end
      pix_q.push_back({1'b1, bus.client_x[8*wcli +: 8], bus.client_y[7*wcli +: 7],
                       bus.client_c[3*wcli +: 3]});
      if (inject_ign && wcli == 0 && wcyc == 4) bus.client_done[3] = 1'b1;
      wcyc++;
      if (dly[wcli] != 0 && wcyc == dly[wcli]) begin
        bus.client_done[wcli] = 1'b1;
        wcli = -1;
      end else if (wcyc == TO) begin
        wcli = -1;
      end
    end else begin
      pix_q.push_back('0);
    end
    if (nxt >= 0) begin
      wcli = nxt;
      wcyc = 0;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic push_frame(input int t0, input int n, input int gap);
    tick_q.push_back(t0);
    for (int k = 0; k < n; k++) start_q.push_back('{t0 + gap*k, k});
  endtask

  int cb;
  int bw;
  int bc;
  int tb_q[$];
  int sb_q[$];

  initial begin
    bus.client_done   = '0;
    bus.client_x      = '0;
    bus.client_y      = '0;
    bus.client_c      = '0;
    bus_b.client_done = '0;
    bus_b.client_x    = '0;
    bus_b.client_y    = '0;
    bus_b.client_c    = '0;
    for (int i = 0; i < NC; i++) dly[i] = 17;

    step();
    step();
    check("rst_outs", outs_a(), 32'(0));
    resetn = 1'b1;
    cyc    = 0;

    // Frame 1: all clients answer after 17 cycles; stray done[3] while on client 0.
    inject_ign = 1'b1;
    push_frame(100, NC, 19);
    run_to(99);
    check("busy_pre", 32'(bus.busy), 32'(0));
    run_to(123);
    check("pix_fixed", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
          32'({1'b1, 8'd75, 7'd120, 3'd7}));
    run_to(175);
    check("busy_last", 32'(bus.busy), 32'(1));
    run_to(176);
    check("busy_drop", 32'(bus.busy), 32'(0));
    check("tmo_f1", 32'(bus.timeout_err), 32'(0));
    check("ovr_f1", 32'(bus.overrun), 32'(0));
    inject_ign = 1'b0;

    // Frame 2: client 2 never answers.
    dly[2] = 0;
    tick_q.push_back(200);
    start_q.push_back('{200, 0});
    start_q.push_back('{219, 1});
    start_q.push_back('{238, 2});
    start_q.push_back('{260, 3});
    run_to(258);
    check("tmo_before", 32'(bus.timeout_err), 32'(0));
    run_to(259);
    check("tmo_set", 32'(bus.timeout_err), 32'(1));
    run_to(279);
    check("busy_f2", 32'(bus.busy), 32'(0));
    check("ovr_f2", 32'(bus.overrun), 32'(0));
    dly[2] = 17;

    // Frame 3: reset asynchronously while waiting on client 1.
    push_frame(300, 2, 19);
    run_to(320);
    check("tmo_sticky", 32'(bus.timeout_err), 32'(1));
    run_to(325);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_mid", outs_a(), 32'(0));
    pix_q.delete();
    start_q.delete();
    tick_q.delete();
    wcli = -1;
    repeat (3) step();
    resetn = 1'b1;
    cyc    = 0;
    push_frame(100, NC, 19);
    run_to(180);
    check("busy_after_rst", 32'(bus.busy), 32'(0));
    check("tmo_after_rst", 32'(bus.timeout_err), 32'(0));
    check("start_left", 32'(start_q.size()), 32'(0));
    check("tick_left", 32'(tick_q.size()), 32'(0));

    // Second instance: 40-cycle clients overrun a 100-cycle frame.
    check("b_rst_outs", outs_b(), 32'(0));
    tb_q     = '{100, 300};
    sb_q     = '{100, 142, 184, 226, 300};
    resetn_b = 1'b1;
    cb       = 0;
    bw       = -1;
    bc       = 0;
    while (cb < 310) begin
      @(posedge clk);
      #1;
      cb++;
      if (bus_b.frame_tick) begin
        if (tb_q.size() > 0) check("b_tick_cyc", 32'(cb), 32'(tb_q.pop_front()));
        else                 check("b_tick_unexp", 32'(bus_b.frame_tick), 32'(0));
      end
      bus_b.client_done = '0;
      if (bw >= 0) begin
        bc++;
        if (bc == 40) begin
          bus_b.client_done[bw] = 1'b1;
          bw = -1;
        end
      end
      if (bus_b.client_start != '0) begin
        if (sb_q.size() > 0) check("b_start_cyc", 32'(cb), 32'(sb_q.pop_front()));
        else                 check("b_start_unexp", 32'(bus_b.client_start), 32'(0));
        for (int i = 0; i < NC; i++) if (bus_b.client_start[i]) bw = i;
        bc = 0;
      end
      if (cb == 199) check("b_ovr_before", 32'(bus_b.overrun), 32'(0));
      if (cb == 200) check("b_ovr_set", 32'(bus_b.overrun), 32'(1));
      if (cb == 267) check("b_busy_last", 32'(bus_b.busy), 32'(1));
      if (cb == 268) check("b_busy_drop", 32'(bus_b.busy), 32'(0));
    end
    check("b_ovr_sticky", 32'(bus_b.overrun), 32'(1));
    check("b_tmo", 32'(bus_b.timeout_err), 32'(0));
    check("b_start_left", 32'(sb_q.size()), 32'(0));
    check("b_tick_left", 32'(tb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
